// File: rtl/qsn_inverse_shift_ctrl_if.sv
// Handshake bundle between the forward shift source / return-path consumer
// and the QSN inverse-shift controller.
//
// Handshake semantics:
//   - fwd_valid/fwd_ready follow strict valid/ready rules. A push happens on a
//     sys_clk edge where both are high.
//   - fwd_ready is not a precondition for asserting fwd_valid. fwd_valid while
//     not ready is an overflow event.
//   - ret_req has no ready. It is a one-cycle request.
//   - inv_valid answers ret_req exactly one cycle later, or stays low if the
//     FIFO was empty.
interface qsn_inverse_shift_ctrl_if #(
  parameter int SHIFT_WIDTH = 7,
  parameter int PTR_WIDTH   = 4
);
  logic                   fwd_valid;
  logic [SHIFT_WIDTH-1:0] fwd_shift;
  logic                   fwd_ready;
  logic                   ret_req;
  logic                   flush;
  logic                   err_clr;
  logic                   inv_valid;
  logic [SHIFT_WIDTH-1:0] inv_shift;
  logic [PTR_WIDTH:0]     occupancy;
  logic                   err_overflow;
  logic                   err_underflow;
  logic                   err_range;

  modport master (
    output fwd_valid, fwd_shift, ret_req, flush, err_clr,
    input  fwd_ready, inv_valid, inv_shift, occupancy,
    input  err_overflow, err_underflow, err_range
  );

  modport slave (
    input  fwd_valid, fwd_shift, ret_req, flush, err_clr,
    output fwd_ready, inv_valid, inv_shift, occupancy,
    output err_overflow, err_underflow, err_range
  );
endinterface

// File: rtl/qsn_inverse_shift_ctrl.sv
// Records the forward QSN shift of each page in a FIFO and issues the inverse
// shift (Z - s) mod Z when the page returns from the check-node array.
module qsn_inverse_shift_ctrl #(
  parameter int CHECK_PARALLELISM = 85,
  parameter int SHIFT_WIDTH       = 7,
  parameter int DEPTH             = 16,
  parameter int PTR_WIDTH         = 4
) (
  input  logic                    sys_clk,
  input  logic                    rstn,
  qsn_inverse_shift_ctrl_if.slave bus
);

  // If Z == 2^SHIFT_WIDTH this truncates to 0. The modular subtraction below
  // still yields Z - s in that case.
  localparam logic [SHIFT_WIDTH-1:0] Z_SW      = SHIFT_WIDTH'(CHECK_PARALLELISM);
  localparam logic [PTR_WIDTH:0]     DEPTH_CNT = (PTR_WIDTH+1)'(DEPTH);

  logic [SHIFT_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_WIDTH-1:0]   r_wr_ptr;
  logic [PTR_WIDTH-1:0]   r_rd_ptr;
  logic [PTR_WIDTH:0]     r_occ;
  logic                   r_inv_valid;
  logic [SHIFT_WIDTH-1:0] r_inv_shift;
  logic                   r_err_overflow;
  logic                   r_err_underflow;
  logic                   r_err_range;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_in_range;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_ov_evt;
  logic                   w_un_evt;
  logic                   w_rg_evt;
  logic [SHIFT_WIDTH-1:0] w_wr_data;
  logic [SHIFT_WIDTH-1:0] w_rd_data;
  logic [SHIFT_WIDTH-1:0] w_inv;

  assign w_full     = (r_occ == DEPTH_CNT);
  assign w_empty    = (r_occ == '0);
  assign w_in_range = ({{(32-SHIFT_WIDTH){1'b0}}, bus.fwd_shift} < 32'(CHECK_PARALLELISM));

  // Flush swallows the whole cycle: no transfer and no error event.
  assign w_push   = bus.fwd_valid & ~w_full  & ~bus.flush;
  assign w_pop    = bus.ret_req   & ~w_empty & ~bus.flush;
  assign w_ov_evt = bus.fwd_valid &  w_full  & ~bus.flush;
  assign w_un_evt = bus.ret_req   &  w_empty & ~bus.flush;
  assign w_rg_evt = w_push & ~w_in_range;

  assign w_wr_data = w_in_range ? bus.fwd_shift : '0;
  assign w_rd_data = r_mem[r_rd_ptr];
  assign w_inv     = (w_rd_data == '0) ? '0 : (Z_SW - w_rd_data);

  // Storage is not reset. Clearing the pointers is enough to discard entries.
  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_occ       <= '0;
      r_inv_valid <= 1'b0;
      r_inv_shift <= '0;
    end else if (bus.flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_occ       <= '0;
      r_inv_valid <= 1'b0;
    end else begin
      r_inv_valid <= w_pop;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + 1'b1;
        r_inv_shift <= w_inv;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // A new error event beats a same-cycle clear. Flush leaves the flags alone.
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
      r_err_range     <= 1'b0;
    end else if (!bus.flush) begin
      if (w_ov_evt) begin
        r_err_overflow <= 1'b1;
      end else if (bus.err_clr) begin
        r_err_overflow <= 1'b0;
      end
      if (w_un_evt) begin
        r_err_underflow <= 1'b1;
      end else if (bus.err_clr) begin
        r_err_underflow <= 1'b0;
      end
      if (w_rg_evt) begin
        r_err_range <= 1'b1;
      end else if (bus.err_clr) begin
        r_err_range <= 1'b0;
      end
    end
  end

  assign bus.fwd_ready     = ~w_full;
  assign bus.inv_valid     = r_inv_valid;
  assign bus.inv_shift     = r_inv_shift;
  assign bus.occupancy     = r_occ;
  assign bus.err_overflow  = r_err_overflow;
  assign bus.err_underflow = r_err_underflow;
  assign bus.err_range     = r_err_range;

endmodule

// File: tb/tb_qsn_inverse_shift_ctrl.sv
// Self-checking bench for qsn_inverse_shift_ctrl. A queue-based reference model
// predicts every output, and the directed tests also check literal values.
module tb_qsn_inverse_shift_ctrl;
  localparam int Z  = 85;
  localparam int SW = 7;
  localparam int D  = 16;
  localparam int PW = 4;

  logic sys_clk;
  logic rstn;
  int   checks;
  int   errors;

  // Reference model state
  int mq[$];
  bit m_iv;
  int m_is;
  bit m_ov, m_un, m_rg;

  qsn_inverse_shift_ctrl_if #(.SHIFT_WIDTH(SW), .PTR_WIDTH(PW)) bus ();

  qsn_inverse_shift_ctrl #(
    .CHECK_PARALLELISM(Z), .SHIFT_WIDTH(SW), .DEPTH(D), .PTR_WIDTH(PW)
  ) dut (
    .sys_clk (sys_clk),
    .rstn    (rstn),
    .bus     (bus)
  );

  // Clock / reset block
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Driver tasks
  task automatic model_reset();
    mq.delete();
    m_iv = 0; m_is = 0;
    m_ov = 0; m_un = 0; m_rg = 0;
  endtask

  task automatic do_reset(input bit busy);
    @(negedge sys_clk);
    rstn          = 1'b0;
    bus.fwd_valid = busy;
    bus.fwd_shift = 7'd33;
    bus.ret_req   = busy;
    bus.flush     = 1'b0;
    bus.err_clr   = 1'b0;
    @(posedge sys_clk);
    model_reset();
    #1;
    @(negedge sys_clk);
    rstn          = 1'b1;
    bus.fwd_valid = 1'b0;
    bus.ret_req   = 1'b0;
  endtask

  // One clock with the given inputs; the model advances on the same edge.
  task automatic step(input bit fv, input int fs, input bit rr, input bit fl, input bit ec);
    bit full, empty, push, pop, ev_ov, ev_un, ev_rg;
    int s;
    @(negedge sys_clk);
    bus.fwd_valid = fv;
    bus.fwd_shift = 7'(fs);
    bus.ret_req   = rr;
    bus.flush     = fl;
    bus.err_clr   = ec;
    @(posedge sys_clk);
    if (fl) begin
      mq.delete();
      m_iv = 0;
    end else begin
      full  = (mq.size() == D);
      empty = (mq.size() == 0);
      push  = fv && !full;
      pop   = rr && !empty;
      ev_ov = fv && full;
      ev_un = rr && empty;
      ev_rg = push && (fs >= Z);
      m_iv  = pop;
      if (pop) begin
        s    = mq.pop_front();
        m_is = (Z - s) % Z;
      end
      if (push) mq.push_back((fs >= Z) ? 0 : fs);
      m_ov = ev_ov ? 1'b1 : (ec ? 1'b0 : m_ov);
      m_un = ev_un ? 1'b1 : (ec ? 1'b0 : m_un);
      m_rg = ev_rg ? 1'b1 : (ec ? 1'b0 : m_rg);
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  // Tests
  task automatic test_reset();
    do_reset(1);
    checks++;
    if (bus.occupancy !== 5'd0 || bus.inv_valid !== 1'b0 || bus.inv_shift !== 7'd0) begin
      errors++;
      $display("FAIL reset_state occ=%0d iv=%0b is=%0d exp 0/0/0", bus.occupancy, bus.inv_valid, bus.inv_shift);
    end
    checks++;
    if ({bus.err_overflow, bus.err_underflow, bus.err_range} !== 3'b000 || bus.fwd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags flags=%b rdy=%0b exp 000/1", {bus.err_overflow, bus.err_underflow, bus.err_range}, bus.fwd_ready);
    end
  endtask

  task automatic test_basic();
    int exp_v[3];
    int vals[3];
    vals = '{10, 0, 84};
    exp_v = '{75, 0, 1};
    do_reset(0);
    for (int i = 0; i < 3; i++) step(1, vals[i], 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 0);
      checks++;
      if (bus.inv_valid !== 1'b1 || int'(bus.inv_shift) != exp_v[i] || int'(bus.inv_shift) != m_is) begin
        errors++;
        $display("FAIL basic_pop%0d iv=%0b is=%0d exp 1/%0d", i, bus.inv_valid, bus.inv_shift, exp_v[i]);
      end
    end
    checks++;
    if (bus.occupancy !== 5'd0 || {bus.err_overflow, bus.err_underflow, bus.err_range} !== 3'b000) begin
      errors++;
      $display("FAIL basic_end occ=%0d flags=%b exp 0/000", bus.occupancy, {bus.err_overflow, bus.err_underflow, bus.err_range});
    end
    idle();
    checks++;
    if (bus.inv_valid !== 1'b0 || bus.inv_shift !== 7'd1) begin
      errors++;
      $display("FAIL basic_hold iv=%0b is=%0d exp 0/1", bus.inv_valid, bus.inv_shift);
    end
  endtask

  task automatic test_full();
    int e;
    do_reset(0);
    for (int i = 0; i < D; i++) step(1, i, 0, 0, 0);
    checks++;
    if (bus.occupancy !== 5'd16 || bus.fwd_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_occ occ=%0d rdy=%0b exp 16/0", bus.occupancy, bus.fwd_ready);
    end
    step(1, 50, 0, 0, 0);
    checks++;
    if (bus.err_overflow !== 1'b1 || bus.occupancy !== 5'd16) begin
      errors++;
      $display("FAIL full_overflow ov=%0b occ=%0d exp 1/16", bus.err_overflow, bus.occupancy);
    end
    for (int i = 0; i < D; i++) begin
      step(0, 0, 1, 0, 0);
      e = (i == 0) ? 0 : Z - i;
      checks++;
      if (bus.inv_valid !== 1'b1 || int'(bus.inv_shift) != e || int'(bus.inv_shift) != m_is) begin
        errors++;
        $display("FAIL full_pop%0d iv=%0b is=%0d exp 1/%0d", i, bus.inv_valid, bus.inv_shift, e);
      end
    end
    step(0, 0, 0, 0, 1);
    checks++;
    if (bus.occupancy !== 5'd0 || bus.err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_drain occ=%0d ov=%0b exp 0/0", bus.occupancy, bus.err_overflow);
    end
  endtask

  task automatic test_full_simul();
    int e;
    do_reset(0);
    for (int i = 0; i < D; i++) step(1, $urandom_range(0, Z-1), 0, 0, 0);
    e = (Z - mq[0]) % Z;
    step(1, 7, 1, 0, 0);
    checks++;
    if (bus.inv_valid !== 1'b1 || int'(bus.inv_shift) != e) begin
      errors++;
      $display("FAIL simul_pop iv=%0b is=%0d exp 1/%0d", bus.inv_valid, bus.inv_shift, e);
    end
    checks++;
    if (bus.occupancy !== 5'd15 || bus.fwd_ready !== 1'b1 || bus.err_overflow !== 1'b1) begin
      errors++;
      $display("FAIL simul_state occ=%0d rdy=%0b ov=%0b exp 15/1/1", bus.occupancy, bus.fwd_ready, bus.err_overflow);
    end
    // Flush with push and pop asserted: both ignored, flags untouched
    step(1, 3, 1, 1, 0);
    checks++;
    if (bus.occupancy !== 5'd0 || bus.inv_valid !== 1'b0 || bus.err_overflow !== 1'b1 || bus.err_underflow !== 1'b0) begin
      errors++;
      $display("FAIL flush occ=%0d iv=%0b ov=%0b un=%0b exp 0/0/1/0", bus.occupancy, bus.inv_valid, bus.err_overflow, bus.err_underflow);
    end
  endtask

  task automatic test_underflow();
    do_reset(0);
    step(1, 5, 1, 0, 0);
    checks++;
    if (bus.inv_valid !== 1'b0 || bus.err_underflow !== 1'b1 || bus.occupancy !== 5'd1) begin
      errors++;
      $display("FAIL underflow iv=%0b un=%0b occ=%0d exp 0/1/1", bus.inv_valid, bus.err_underflow, bus.occupancy);
    end
    step(0, 0, 1, 0, 0);
    checks++;
    if (bus.inv_valid !== 1'b1 || bus.inv_shift !== 7'd80) begin
      errors++;
      $display("FAIL underflow_pop iv=%0b is=%0d exp 1/80", bus.inv_valid, bus.inv_shift);
    end
    // Error event wins over a same-cycle clear
    step(0, 0, 1, 0, 1);
    checks++;
    if (bus.err_underflow !== 1'b1) begin
      errors++;
      $display("FAIL clr_collision un=%0b exp 1", bus.err_underflow);
    end
    step(0, 0, 0, 0, 1);
    checks++;
    if (bus.err_underflow !== 1'b0) begin
      errors++;
      $display("FAIL err_clr un=%0b exp 0", bus.err_underflow);
    end
  endtask

  task automatic test_range();
    do_reset(0);
    step(1, 90, 0, 0, 0);
    checks++;
    if (bus.err_range !== 1'b1 || bus.occupancy !== 5'd1) begin
      errors++;
      $display("FAIL range_flag rg=%0b occ=%0d exp 1/1", bus.err_range, bus.occupancy);
    end
    step(1, 84, 1, 0, 0);
    checks++;
    if (bus.inv_valid !== 1'b1 || bus.inv_shift !== 7'd0) begin
      errors++;
      $display("FAIL range_pop iv=%0b is=%0d exp 1/0", bus.inv_valid, bus.inv_shift);
    end
    step(0, 0, 1, 0, 0);
    checks++;
    if (bus.inv_shift !== 7'd1 || bus.err_range !== 1'b1) begin
      errors++;
      $display("FAIL range_next is=%0d rg=%0b exp 1/1", bus.inv_shift, bus.err_range);
    end
  endtask

  task automatic test_wrap_reset();
    do_reset(0);
    for (int i = 0; i < 4; i++) step(1, $urandom_range(0, Z-1), 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, $urandom_range(0, Z-1), 1, 0, 0);
      checks++;
      if (bus.inv_valid !== 1'b1 || int'(bus.inv_shift) != m_is || bus.occupancy !== 5'd4) begin
        errors++;
        $display("FAIL wrap%0d iv=%0b is=%0d occ=%0d exp 1/%0d/4", i, bus.inv_valid, bus.inv_shift, bus.occupancy, m_is);
      end
    end
    step(0, 0, 1, 0, 0);
    do_reset(1);
    checks++;
    if (bus.occupancy !== 5'd0 || bus.inv_valid !== 1'b0 || bus.inv_shift !== 7'd0 ||
        {bus.err_overflow, bus.err_underflow, bus.err_range} !== 3'b000) begin
      errors++;
      $display("FAIL midreset occ=%0d iv=%0b is=%0d exp 0/0/0", bus.occupancy, bus.inv_valid, bus.inv_shift);
    end
    step(1, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    checks++;
    if (bus.inv_valid !== 1'b1 || bus.inv_shift !== 7'd84) begin
      errors++;
      $display("FAIL post_reset iv=%0b is=%0d exp 1/84", bus.inv_valid, bus.inv_shift);
    end
  endtask

  task automatic test_random();
    int fv_pct, rr_pct;
    do_reset(0);
    for (int i = 0; i < 600; i++) begin
      fv_pct = ((i / 100) % 2 == 0) ? 80 : 30;
      rr_pct = ((i / 100) % 2 == 0) ? 30 : 80;
      step($urandom_range(0, 99) < fv_pct, $urandom_range(0, 99),
           $urandom_range(0, 99) < rr_pct, $urandom_range(0, 49) == 0,
           $urandom_range(0, 9) == 0);
      checks++;
      if (bus.inv_valid !== m_iv || int'(bus.inv_shift) != m_is) begin
        errors++;
        $display("FAIL rand_inv cyc=%0d iv=%0b is=%0d exp %0b/%0d", i, bus.inv_valid, bus.inv_shift, m_iv, m_is);
      end
      checks++;
      if (int'(bus.occupancy) != mq.size() || bus.fwd_ready !== (mq.size() != D)) begin
        errors++;
        $display("FAIL rand_occ cyc=%0d occ=%0d rdy=%0b exp %0d", i, bus.occupancy, bus.fwd_ready, mq.size());
      end
      checks++;
      if ({bus.err_overflow, bus.err_underflow, bus.err_range} !== {m_ov, m_un, m_rg}) begin
        errors++;
        $display("FAIL rand_flags cyc=%0d flags=%b exp %b", i, {bus.err_overflow, bus.err_underflow, bus.err_range}, {m_ov, m_un, m_rg});
      end
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rstn          = 1'b0;
    bus.fwd_valid = 1'b0;
    bus.fwd_shift = '0;
    bus.ret_req   = 1'b0;
    bus.flush     = 1'b0;
    bus.err_clr   = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_full();
    test_full_simul();
    test_underflow();
    test_range();
    test_wrap_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
